// File: rtl/snake_step_sequencer.sv
// Snake game-flow controller: paces steps from frame_tick, moves the head, resolves eat/death one cycle after each step.
// shift_en is registered on the step edge; no backpressure, the body FIFO must accept every strobe.
module snake_step_sequencer #(
   parameter int STEP_DIV = 4,
   parameter int STEP     = 10,
   parameter int MAX_LEN  = 10,
   parameter int X_MIN    = 150,
   parameter int X_MAX    = 800,
   parameter int Y_MIN    = 34,
   parameter int Y_MAX    = 514
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       body_hit,
   output logic [9:0] head_x,
   output logic [9:0] head_y,
   output logic [1:0] dir,
   output logic       shift_en,
   output logic [3:0] length,
   output logic [9:0] apple_x,
   output logic [9:0] apple_y,
   output logic [7:0] score,
   output logic [1:0] state,
   output logic       game_over
);

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_CHECK = 2'b10, S_DEAD = 2'b11} state_t;

   localparam logic [9:0]  HX0   = 10'd450;
   localparam logic [9:0]  HY0   = 10'd250;
   localparam logic [9:0]  AX0   = 10'd650;
   localparam logic [9:0]  AY0   = 10'd150;
   localparam logic [15:0] LFSR0 = 16'hACE1;

   state_t      st, st_nxt;
   logic [9:0]  head_x_nxt, head_y_nxt, apple_x_nxt, apple_y_nxt;
   logic [1:0]  dir_nxt, pend, pend_nxt;
   logic        shift_nxt;
   logic [3:0]  length_nxt;
   logic [7:0]  score_nxt, cnt, cnt_nxt;
   logic [15:0] lfsr;
   logic        btn_vld;
   logic [1:0]  btn_dir;
   logic [10:0] hx_w, hy_w, hx_step, hy_step;
   logic [9:0]  dx, dy;
   logic        eat;

   assign btn_vld = right | left | up | down;
   assign btn_dir = right ? 2'b00 : left ? 2'b01 : up ? 2'b10 : 2'b11;

   assign hx_w = {1'b0, head_x};
   assign hy_w = {1'b0, head_y};

   // Candidate head for the direction that a step would commit (the pending one).
   always_comb begin
      hx_step = hx_w;
      hy_step = hy_w;
      case (pend)
         2'b00:   hx_step = (hx_w + 11'(STEP) > 11'(X_MAX)) ? 11'(X_MIN) : hx_w + 11'(STEP);
         2'b01:   hx_step = (hx_w < 11'(X_MIN + STEP))      ? 11'(X_MAX) : hx_w - 11'(STEP);
         2'b10:   hy_step = (hy_w < 11'(Y_MIN + STEP))      ? 11'(Y_MAX) : hy_w - 11'(STEP);
         default: hy_step = (hy_w + 11'(STEP) > 11'(Y_MAX)) ? 11'(Y_MIN) : hy_w + 11'(STEP);
      endcase
   end

   assign dx  = (head_x >= apple_x) ? head_x - apple_x : apple_x - head_x;
   assign dy  = (head_y >= apple_y) ? head_y - apple_y : apple_y - head_y;
   assign eat = (dx <= 10'd7) && (dy <= 10'd7);

   always_comb begin
      st_nxt      = st;
      head_x_nxt  = head_x;
      head_y_nxt  = head_y;
      dir_nxt     = dir;
      pend_nxt    = pend;
      shift_nxt   = 1'b0;
      length_nxt  = length;
      score_nxt   = score;
      apple_x_nxt = apple_x;
      apple_y_nxt = apple_y;
      cnt_nxt     = cnt;

      // Reversal is judged against the committed direction, not the pending one.
      if (btn_vld && btn_dir != (dir ^ 2'b01))
         pend_nxt = btn_dir;

      case (st)
         S_IDLE: begin
            cnt_nxt = 8'd0;
            if (start) st_nxt = S_RUN;
         end
         S_RUN: begin
            if (frame_tick) begin
               if (cnt == 8'(STEP_DIV - 1)) begin
                  cnt_nxt    = 8'd0;
                  dir_nxt    = pend;
                  head_x_nxt = hx_step[9:0];
                  head_y_nxt = hy_step[9:0];
                  shift_nxt  = 1'b1;
                  st_nxt     = S_CHECK;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         S_CHECK: begin
            if (frame_tick) cnt_nxt = cnt + 8'd1;
            if (body_hit) begin
               st_nxt = S_DEAD;
            end else begin
               st_nxt = S_RUN;
               if (eat) begin
                  if (length < 4'(MAX_LEN)) length_nxt = length + 4'd1;
                  if (score != 8'hFF)       score_nxt  = score + 8'd1;
                  apple_x_nxt = 10'(X_MIN) + 10'(lfsr[5:0]) * 10'd10;
                  apple_y_nxt = 10'(Y_MIN) + 10'(lfsr[10:6]) * 10'd10;
               end
            end
         end
         default: begin
            if (start) begin
               st_nxt      = S_IDLE;
               head_x_nxt  = HX0;
               head_y_nxt  = HY0;
               dir_nxt     = 2'b00;
               pend_nxt    = 2'b00;
               length_nxt  = 4'd1;
               score_nxt   = 8'd0;
               apple_x_nxt = AX0;
               apple_y_nxt = AY0;
               cnt_nxt     = 8'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= S_IDLE;
         head_x   <= HX0;
         head_y   <= HY0;
         dir      <= 2'b00;
         pend     <= 2'b00;
         shift_en <= 1'b0;
         length   <= 4'd1;
         score    <= 8'd0;
         apple_x  <= AX0;
         apple_y  <= AY0;
         cnt      <= 8'd0;
         lfsr     <= LFSR0;
      end else begin
         st       <= st_nxt;
         head_x   <= head_x_nxt;
         head_y   <= head_y_nxt;
         dir      <= dir_nxt;
         pend     <= pend_nxt;
         shift_en <= shift_nxt;
         length   <= length_nxt;
         score    <= score_nxt;
         apple_x  <= apple_x_nxt;
         apple_y  <= apple_y_nxt;
         cnt      <= cnt_nxt;
         lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign state     = st;
   assign game_over = (st == S_DEAD);

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Bench for snake_step_sequencer: game model predicts each step and each CHECK outcome into queues; a monitor pops and compares.
module tb_snake_step_sequencer;
   localparam int STEP_DIV = 2;

   logic       clk = 1'b0, rst = 1'b0, frame_tick = 1'b0, start = 1'b0;
   logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, body_hit = 1'b0;
   logic [9:0] head_x, head_y, apple_x, apple_y;
   logic [1:0] dir, state;
   logic       shift_en, game_over;
   logic [3:0] length;
   logic [7:0] score;

   always #5 clk = ~clk;

   snake_step_sequencer #(.STEP_DIV(STEP_DIV)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .up(up), .down(down), .left(left), .right(right), .body_hit(body_hit),
      .head_x(head_x), .head_y(head_y), .dir(dir), .shift_en(shift_en),
      .length(length), .apple_x(apple_x), .apple_y(apple_y), .score(score),
      .state(state), .game_over(game_over)
   );

   typedef struct {int hx; int hy; int d;} step_exp_t;
   typedef struct {int st; int len; int sc; int ax; int ay;} out_exp_t;
   step_exp_t q_step[$];
   out_exp_t  q_out[$];

   int n_chk = 0, n_pass = 0, n_shift = 0;
   int m_state, m_cnt, m_dir, m_pend, m_hx, m_hy, m_len, m_score, m_ax, m_ay;
   logic [15:0] m_lfsr;

   always @(posedge clk or posedge rst)
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_dir = 0; m_pend = 0; m_hx = 450; m_hy = 250;
      m_len = 1; m_score = 0; m_ax = 650; m_ay = 150;
      q_step.delete(); q_out.delete();
   endtask

   function automatic void next_head(input int d, input int x, input int y, output int ox, output int oy);
      ox = x; oy = y;
      case (d)
         0: ox = (x + 10 > 800) ? 150 : x + 10;
         1: ox = (x < 160) ? 800 : x - 10;
         2: oy = (y < 44) ? 514 : y - 10;
         default: oy = (y + 10 > 514) ? 34 : y + 10;
      endcase
   endfunction

   function automatic bit in_window(input int x, input int y);
      int ax = (x > m_ax) ? x - m_ax : m_ax - x;
      int ay = (y > m_ay) ? y - m_ay : m_ay - y;
      return (ax <= 7) && (ay <= 7);
   endfunction

   initial begin : monitor
      step_exp_t e;
      out_exp_t  o;
      int        prev_st;
      prev_st = 0;
      forever begin
         @(negedge clk);
         if (rst) prev_st = 0;
         else begin
            if (shift_en) begin
               n_shift++;
               if (q_step.size() == 0) check("spurious_shift", 1, 0);
               else begin
                  e = q_step.pop_front();
                  check("step_head_x", head_x, e.hx);
                  check("step_head_y", head_y, e.hy);
                  check("step_dir", dir, e.d);
               end
            end
            if (prev_st == 2) begin
               if (q_out.size() == 0) check("unexpected_check", 1, 0);
               else begin
                  o = q_out.pop_front();
                  check("out_state", state, o.st);
                  check("out_length", length, o.len);
                  check("out_score", score, o.sc);
                  check("out_apple_x", apple_x, o.ax);
                  check("out_apple_y", apple_y, o.ay);
                  check("out_game_over", game_over, (o.st == 3) ? 1 : 0);
               end
            end
            prev_st = state;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_game();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      if (m_state == 0) m_state = 1;
      else if (m_state == 3) begin
         m_state = 0; m_cnt = 0; m_dir = 0; m_pend = 0; m_hx = 450; m_hy = 250;
         m_len = 1; m_score = 0; m_ax = 650; m_ay = 150;
      end
   endtask

   task automatic press(input int d);
      @(negedge clk);
      right = (d == 0); left = (d == 1); up = (d == 2); down = (d == 3);
      @(negedge clk);
      {right, left, up, down} = 4'b0;
      if (d != (m_dir ^ 1)) m_pend = d;
   endtask

   task automatic tick(input bit hit);
      bit s;
      step_exp_t e;
      out_exp_t  o;
      s = 1'b0;
      @(negedge clk);
      frame_tick = 1'b1; body_hit = hit;
      if (m_state == 1) begin
         if (m_cnt == STEP_DIV - 1) begin
            s = 1'b1; m_cnt = 0; m_dir = m_pend;
            next_head(m_dir, m_hx, m_hy, m_hx, m_hy);
            e.hx = m_hx; e.hy = m_hy; e.d = m_dir;
            q_step.push_back(e);
         end else m_cnt++;
      end
      @(posedge clk); #1;
      if (s) begin
         if (hit) m_state = 3;
         else begin
            m_state = 1;
            if (in_window(m_hx, m_hy)) begin
               if (m_len < 10) m_len++;
               if (m_score < 255) m_score++;
               m_ax = 150 + 10 * int'(m_lfsr[5:0]);
               m_ay = 34 + 10 * int'(m_lfsr[10:6]);
            end
         end
         o.st = m_state; o.len = m_len; o.sc = m_score; o.ax = m_ax; o.ay = m_ay;
         q_out.push_back(o);
      end
      @(negedge clk); frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      body_hit = 1'b0;
   endtask

   task automatic do_step();
      tick(1'b0);
      tick(1'b0);
   endtask

   // Steer toward the apple; with die set, the step that would land in the apple window carries body_hit.
   task automatic chase(input int target, input bit die);
      int it, dxx, dyy, want, nx, ny;
      bit hit;
      it = 0;
      while (m_state == 1 && (die || m_score < target) && it < 3000) begin
         it++;
         dxx = m_ax - m_hx; dyy = m_ay - m_hy;
         if (dxx > 7 || dxx < -7)      want = (dxx > 0) ? 0 : 1;
         else if (dyy > 7 || dyy < -7) want = (dyy > 0) ? 3 : 2;
         else                          want = m_dir;
         if (want == (m_dir ^ 1)) want = (m_dir < 2) ? 2 : 0;
         press(want);
         next_head(m_pend, m_hx, m_hy, nx, ny);
         hit = die && in_window(nx, ny);
         tick(1'b0);
         tick(hit);
      end
      check("chase_bound", (it < 3000) ? 1 : 0, 1);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      int s0, g;
      do_reset();
      @(negedge clk);
      check("rst_state", state, 0);
      check("rst_head_x", head_x, 450);
      check("rst_head_y", head_y, 250);
      check("rst_dir", dir, 0);
      check("rst_length", length, 1);
      check("rst_score", score, 0);
      check("rst_apple_x", apple_x, 650);
      check("rst_apple_y", apple_y, 150);
      check("rst_shift_en", shift_en, 0);
      check("rst_game_over", game_over, 0);

      // Basic stepping: four ticks at STEP_DIV=2 give two steps right.
      start_game();
      s0 = n_shift;
      repeat (4) tick(1'b0);
      check("basic_pulses", n_shift - s0, 2);
      check("basic_head_x", head_x, 470);
      check("basic_head_y", head_y, 250);
      check("basic_dir", dir, 0);
      check("basic_state", state, 1);

      // Reversal filter.
      press(1); do_step();
      check("rev_ignored_dir", dir, 0);
      press(2); do_step();
      check("rev_up_dir", dir, 2);
      press(1); do_step();
      check("rev_left_dir", dir, 1);

      // Wrap on both axes.
      do_reset();
      start_game();
      g = 0;
      while (m_hx != 800 && g < 100) begin do_step(); g++; end
      check("wrap_reach_x", head_x, 800);
      do_step();
      check("wrap_head_x", head_x, 150);
      press(2); do_step();
      g = 0;
      while (m_hy != 40 && g < 100) begin do_step(); g++; end
      check("wrap_reach_y", head_y, 40);
      do_step();
      check("wrap_head_y", head_y, 514);

      // Eat, grow, saturate length.
      do_reset();
      start_game();
      chase(1, 1'b0);
      check("eat1_length", length, 2);
      check("eat1_score", score, 1);
      chase(12, 1'b0);
      check("sat_length", length, 10);
      check("sat_score", score, 12);

      // Death has priority over eating.
      chase(0, 1'b1);
      check("dead_state", state, 3);
      check("dead_game_over", game_over, 1);
      check("dead_length", length, 10);
      check("dead_score", score, 12);
      s0 = n_shift;
      repeat (4) tick(1'b0);
      check("dead_no_shift", n_shift - s0, 0);
      start_game();
      @(negedge clk);
      check("restart_state", state, 0);
      check("restart_head_x", head_x, 450);
      check("restart_head_y", head_y, 250);
      check("restart_length", length, 1);
      check("restart_score", score, 0);

      // Asynchronous reset with the step counter part way.
      start_game();
      tick(1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("arst_state", state, 0);
      check("arst_head_x", head_x, 450);
      check("arst_head_y", head_y, 250);
      check("arst_length", length, 1);
      check("arst_shift_en", shift_en, 0);
      @(negedge clk); rst = 1'b0;
      s0 = n_shift;
      repeat (6) tick(1'b0);
      check("arst_no_shift", n_shift - s0, 0);
      check("arst_idle", state, 0);

      check("sb_step_empty", q_step.size(), 0);
      check("sb_out_empty", q_out.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/snake_step_sequencer.md
Name: snake_step_sequencer

Overview:
- Game-flow controller for the VGA snake datapath.
- Decides when the snake advances, which way it moves, and whether it grows or dies. Keeps the apple position and score.
- Drives head coordinates and a one-cycle shift strobe into the body FIFO/renderer. Takes back a head-on-body hit flag.
- Runs on the game clock; the display timing block supplies frame_tick.

Parameters:
- STEP_DIV, 4: frame_ticks per snake step (2..255).
- STEP, 10: pixels moved per step.
- MAX_LEN, 10: maximum snake length in segments (head included).
- X_MIN, 150 / X_MAX, 800: horizontal wrap limits, pixels.
- Y_MIN, 34 / Y_MAX, 514: vertical wrap limits, pixels.

Ports:
- clk  in  1  game clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  level; begins or restarts a game.
- up, down, left, right  in  1 each  debounced button levels.
- body_hit  in  1  head overlaps a body segment; valid in the cycle after shift_en.
- head_x, head_y  out  10 each  head centre, pixels.
- dir  out  2  committed direction: 00 right, 01 left, 10 up, 11 down.
- shift_en  out  1  one-cycle strobe: body FIFO shifts and captures the old head.
- length  out  4  current segment count.
- apple_x, apple_y  out  10 each  apple centre.
- score  out  8  apples eaten.
- state  out  2  00 IDLE, 01 RUN, 10 CHECK, 11 DEAD.
- game_over  out  1  high exactly when state==DEAD.

Behaviour:
- Reset values (asynchronous): state IDLE, head (450,250), dir 00, pending dir 00, length 1, score 0, apple (650,150), shift_en 0, step counter 0, LFSR 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every clk in all states.
- Pending direction:
  - Sampled every clk. Button priority right > left > up > down.
  - A request for the reverse of the committed dir is ignored; the pending value stays unchanged.
  - Pending is copied to dir only on a step cycle.
- IDLE:
  - Outputs hold their reset game values; step counter held at 0.
  - start=1 -> RUN on the next edge.
- RUN:
  - Step counter increments on each frame_tick.
  - When frame_tick arrives with counter==STEP_DIV-1, that cycle is the step cycle:
    - counter clears;
    - dir <= pending;
    - head updated using the new dir;
    - shift_en=1 (registered, same edge as the head update);
    - state -> CHECK.
- Head update:
  - right: head_x+STEP>X_MAX ? X_MIN : head_x+STEP.
  - left: head_x<X_MIN+STEP ? X_MAX : head_x-STEP.
  - up and down: same rules on head_y with Y_MIN/Y_MAX.
  - All arithmetic is 11-bit internally to avoid overflow before comparison.
- CHECK (exactly one cycle, then RUN or DEAD):
  - body_hit=1 -> DEAD. body_hit has priority over eating; length and score unchanged.
  - Otherwise, eat occurs if |head_x-apple_x|<=7 and |head_y-apple_y|<=7. On eat:
    - length+1, saturating at MAX_LEN;
    - score+1, saturating at 255;
    - apple_x <= X_MIN+10*lfsr[5:0];
    - apple_y <= Y_MIN+10*lfsr[10:6], using the LFSR value in that cycle.
- Step counter runs through CHECK, so a frame_tick arriving during CHECK is counted.
- DEAD:
  - All outputs frozen; buttons still update pending dir.
  - start=1 -> reinitialise the game values (not the LFSR) and go to IDLE.
- start in RUN or CHECK is ignored.
- shift_en is never high outside the cycle after a step.
- Reset mid-game: immediate return to reset values, with no further shift_en pulse.

Test Plan:
- Basic step: STEP_DIV=2; reset, start, no buttons, 4 frame_ticks -> exactly 2 shift_en pulses; head (470,250); dir 00; state back to 01.
- Reversal filter: moving right, assert left for one cycle -> dir stays 00 at the next step. Then up, then left before the following step -> dir 10 at the first step and 01 at the second.
- Wrap: force head to (800,250) moving right, one step -> head_x=150. Moving up at head_y=40 -> head_y=514.
- Eat and grow: drive head toward apple (650,150) until within the window -> in CHECK, length 1->2 and score 0->1. New apple equals the LFSR formula checked against a bench model. Repeat past MAX_LEN -> length holds 10 while score keeps counting.
- Death priority: step with body_hit=1 while also in the apple window -> state DEAD, game_over=1, length and score unchanged. Further frame_ticks produce no shift_en. start -> IDLE with head (450,250) and length 1.
- Async reset mid-RUN (counter nonzero): assert rst between edges -> outputs hit reset values immediately, with no shift_en after release until start is given.
